vme_cmd_arbiter: RTL
====================

Name: vme_cmd_arbiter

Overview:
- Shares the single VME command port (start / vme_cmd_reg / vme_dat_reg_in out, vme_cmd_rd / vme_dat_wr / vme_dat_reg_out in) between NREQ requesters, e.g. the file-driven command player, a calibration-pulse sequencer and slow-control scripts.
- Arbitrates round-robin and builds the 32-bit command word (mask OR'd, read/write bit set).
- Issues one command at a time, waits for the response or a timeout, and returns read data to the granted requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CMD_MASK, 32'h00A80000, constant bits OR'd into every command word; also the idle value of vme_cmd_reg.
- TIMEOUT, 1023, number of WAIT cycles before the transaction is aborted.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level.
- req_rd  in  NREQ  1 = read, 0 = write.
- req_addr  in  16*NREQ  VME instruction; slice i belongs to requester i.
- req_wdata  in  16*NREQ  write data, slice i.
- gnt  out  NREQ  one-hot grant, high from grant until done.
- done  out  NREQ  one-cycle completion pulse.
- rdata  out  16  last read data captured.
- timeout_err  out  1  one-cycle pulse, coincident with done, on timeout.
- busy  out  1  high whenever state is not IDLE.
- vme_cmd_rd  in  1  VME master can accept a command.
- start  out  1  one-cycle command strobe.
- vme_cmd_reg  out  32  command word.
- vme_dat_reg_in  out  32  write data to the VME master.
- vme_dat_reg_out  in  32  response data.
- vme_dat_wr  in  1  response valid.

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, done=0, rdata=0, timeout_err=0, busy=0, start=0, vme_cmd_reg=CMD_MASK, vme_dat_reg_in=0. The RR pointer resets to 0 (requester 0 has highest priority first); the state resets to IDLE.
- Reset is asynchronous and may occur in any state. Any response arriving after reset is ignored.
- IDLE:
  - If any req is high, pick the first requester at or after ptr (circularly), latch its rd/addr/wdata.
  - Next cycle: gnt[i]=1, busy=1, state ISSUE.
- ISSUE:
  - If req[i] has dropped, go to IDLE without issuing. No done pulse, gnt cleared, ptr unchanged.
  - Else if vme_cmd_rd=1, next cycle: start=1, vme_cmd_reg = CMD_MASK | {16'h0,addr} | (rd ? 1<<25 : 1<<24), vme_dat_reg_in = rd ? 0 : {16'h0,wdata}; state WAIT; timeout counter cleared.
  - Else hold in ISSUE.
- WAIT:
  - start=1 only in the first WAIT cycle; vme_dat_wr in that cycle is ignored.
  - Counter increments each cycle.
  - On vme_dat_wr: if rd, rdata <= vme_dat_reg_out[15:0] (writes leave rdata unchanged); go to DONE.
  - When the counter reaches TIMEOUT with no vme_dat_wr: set error flag, go to DONE, rdata unchanged.
  - If vme_dat_wr and the timeout occur in the same cycle, the data wins and no error is flagged.
  - req changes after start are ignored.
  - vme_cmd_reg/vme_dat_reg_in hold their values through WAIT.
- DONE:
  - done[i]=1 for one cycle, timeout_err=error flag, gnt cleared.
  - vme_cmd_reg returns to CMD_MASK, vme_dat_reg_in to 0.
  - ptr <= i+1 mod NREQ; state IDLE.
- Minimum latency: req sampled at cycle 0 → gnt at 1 → start at 2 (vme_cmd_rd high) → done two cycles after vme_dat_wr is sampled.
- Throughput: at most one outstanding transaction; back-to-back grants are separated by one IDLE cycle.

Optional Feature:
- VME_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer is removed.
- Undefined: round-robin as above.

Decomposition:
- Package vme_arb_pkg holds the state enum (IDLE, ISSUE, WAIT, DONE), CMD_MASK default, RD_BIT=25, WR_BIT=24, and the instruction/data width constant 16.
- Sub-module rr_arbiter (req, ptr → one-hot grant, index); the fixed-priority variant lives inside it under the macro.

Test Plan:
- Write, requester 0, addr 16'h4100, wdata 16'h00FF, vme_cmd_rd=1 → start one cycle, vme_cmd_reg=32'h01A84100, vme_dat_reg_in=32'h000000FF. vme_dat_wr 5 cycles later → done[0] pulse, rdata unchanged, vme_cmd_reg back to 32'h00A80000.
- Read, requester 2, addr 16'h3000, response vme_dat_reg_out=32'hDEADBEEF → vme_cmd_reg=32'h02A83000, vme_dat_reg_in=0, rdata=16'hBEEF, done[2] pulse.
- All four req held high → grant order 0,1,2,3,0. With VME_ARB_FIXED_PRIO_EN, requester 0 is granted every time.
- TIMEOUT=16, no vme_dat_wr → timeout_err and done pulse together after 16 WAIT cycles, rdata unchanged. A vme_dat_wr on the 16th cycle → no error.
- vme_cmd_rd held low, req[1] dropped 5 cycles into ISSUE → no start, no done, gnt=0, next request granted normally.
- rst_n asserted mid-WAIT → outputs take their reset values immediately; a vme_dat_wr after release produces no done.

Source files
------------

// File: rtl/vme_arb_pkg.sv
// Shared types and constants for the VME command arbiter: FSM state encoding,
// command-word bit positions and the instruction/data width.
package vme_arb_pkg;

   localparam int          DW           = 16;
   localparam logic [31:0] CMD_MASK_DEF = 32'h00A8_0000;
   localparam int          RD_BIT       = 25;
   localparam int          WR_BIT       = 24;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_e;

   function automatic logic [31:0] build_cmd(input logic [31:0]   mask,
                                             input logic [DW-1:0] addr,
                                             input logic          rd);
      logic [31:0] cmd;
      cmd = mask | {{(32-DW){1'b0}}, addr};
      if (rd) cmd[RD_BIT] = 1'b1;
      else    cmd[WR_BIT] = 1'b1;
      return cmd;
   endfunction

endpackage

// File: rtl/vme_cmd_arbiter_if.sv
// Command/response port between the arbiter (master modport) and the VME
// master engine (slave modport).
interface vme_cmd_arbiter_if;
   logic        start;
   logic [31:0] vme_cmd_reg;
   logic [31:0] vme_dat_reg_in;
   logic        vme_cmd_rd;
   logic [31:0] vme_dat_reg_out;
   logic        vme_dat_wr;

   modport master (
      output start, vme_cmd_reg, vme_dat_reg_in,
      input  vme_cmd_rd, vme_dat_reg_out, vme_dat_wr
   );

   modport slave (
      input  start, vme_cmd_reg, vme_dat_reg_in,
      output vme_cmd_rd, vme_dat_reg_out, vme_dat_wr
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational requester selection: round-robin from ptr, or lowest-index
// fixed priority (no ptr port) when VME_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
   import vme_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
`ifndef VME_ARB_FIXED_PRIO_EN
   input  logic [IW-1:0]   ptr,
`endif
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);

   always_comb begin
      int j;
      j   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef VME_ARB_FIXED_PRIO_EN
         j = k;
`else
         // Circular scan starting at the pointer
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
`endif
         if (!any && req[j]) begin
            any    = 1'b1;
            idx    = IW'(j);
            gnt[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vme_cmd_arbiter.sv
// Shares one VME command port among NREQ requesters, one transaction at a time.
// Define VME_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module vme_cmd_arbiter
   import vme_arb_pkg::*;
#(
   parameter int          NREQ     = 4,
   parameter logic [31:0] CMD_MASK = CMD_MASK_DEF,
   parameter int          TIMEOUT  = 1023
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_rd,
   input  logic [DW*NREQ-1:0] req_addr,
   input  logic [DW*NREQ-1:0] req_wdata,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic [DW-1:0]      rdata,
   output logic               timeout_err,
   output logic               busy,
   vme_cmd_arbiter_if.master  bus
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              rd_q, rd_d;
   logic [DW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              terr_q, terr_d;
   logic              busy_q, busy_d;
   logic              start_q, start_d;
   logic [31:0]       cmd_q, cmd_d;
   logic [31:0]       din_q, din_d;

   logic [NREQ-1:0]   arb_gnt;
   logic [IW-1:0]     arb_idx;
   logic              arb_any;

`ifndef VME_ARB_FIXED_PRIO_EN
   logic [IW-1:0]     ptr_q, ptr_d;
`endif

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req (req),
`ifndef VME_ARB_FIXED_PRIO_EN
      .ptr (ptr_q),
`endif
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      gnt_d   = gnt_q;
      done_d  = '0;
      rdata_d = rdata_q;
      terr_d  = 1'b0;
      start_d = 1'b0;
      cmd_d   = cmd_q;
      din_d   = din_q;
`ifndef VME_ARB_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               idx_d   = arb_idx;
               rd_d    = req_rd[arb_idx];
               addr_d  = req_addr[int'(arb_idx)*DW +: DW];
               wdata_d = req_wdata[int'(arb_idx)*DW +: DW];
               gnt_d   = arb_gnt;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // A requester that gives up before the command goes out is simply released
            if (!req[idx_q]) begin
               gnt_d   = '0;
               state_d = IDLE;
            end else if (bus.vme_cmd_rd) begin
               start_d = 1'b1;
               cmd_d   = build_cmd(CMD_MASK, addr_q, rd_q);
               din_d   = rd_q ? 32'h0 : {{(32-DW){1'b0}}, wdata_q};
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // cnt_q == 0 marks the strobe cycle, whose response input is stale
            if ((cnt_q != '0) && bus.vme_dat_wr) begin
               if (rd_q) rdata_d = bus.vme_dat_reg_out[DW-1:0];
               state_d = DONE;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            done_d[idx_q] = 1'b1;
            terr_d  = err_q;
            gnt_d   = '0;
            cmd_d   = CMD_MASK;
            din_d   = 32'h0;
`ifndef VME_ARB_FIXED_PRIO_EN
            ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         gnt_q   <= '0;
         done_q  <= '0;
         rdata_q <= '0;
         terr_q  <= 1'b0;
         busy_q  <= 1'b0;
         start_q <= 1'b0;
         cmd_q   <= CMD_MASK;
         din_q   <= 32'h0;
`ifndef VME_ARB_FIXED_PRIO_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         rdata_q <= rdata_d;
         terr_q  <= terr_d;
         busy_q  <= busy_d;
         start_q <= start_d;
         cmd_q   <= cmd_d;
         din_q   <= din_d;
`ifndef VME_ARB_FIXED_PRIO_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign gnt                = gnt_q;
   assign done               = done_q;
   assign rdata              = rdata_q;
   assign timeout_err        = terr_q;
   assign busy               = busy_q;
   assign bus.start          = start_q;
   assign bus.vme_cmd_reg    = cmd_q;
   assign bus.vme_dat_reg_in = din_q;

endmodule
